l2_port_arbiter: RTL and testbench

//  Shares the single L1->L2 request port between four requesters:
//  DL1 dirty write-back, DL1 refill, IL1 refill and write-buffer drain.

---
 rtl/l2_port_arbiter_pkg.sv | 27 ++
 rtl/l2_arb_pick.sv | 29 ++
 rtl/l2_port_arbiter.sv | 136 +++++++++++++
 tb/tb_l2_port_arbiter.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/l2_port_arbiter_pkg.sv
// Shared types and defaults for the L1->L2 request port arbiter.
// Source order doubles as the fixed priority order (lowest index wins).
package l2_port_arbiter_pkg;

  localparam int L2ARB_NUM_SRC       = 4;
  localparam int L2ARB_ADDR_W_DEF    = 32;
  localparam int L2ARB_AGE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    SRC_DDIRTY,
    SRC_DREFILL,
    SRC_IREFILL,
    SRC_WB
  } arb_src_e;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_e;

  function automatic logic src_is_write(arb_src_e s);
    return (s == SRC_DDIRTY) || (s == SRC_WB);
  endfunction

endpackage

// File: rtl/l2_arb_pick.sv
// Purpose: combinational winner select, fixed priority with WB age override.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller only consumes the result when idle.
module l2_arb_pick
  import l2_port_arbiter_pkg::*;
(
  input  logic [L2ARB_NUM_SRC-1:0] pend,
  input  logic                     age_hit,
  output arb_src_e                 winner,
  output logic                     valid
);

  always_comb begin
    winner = SRC_DDIRTY;
    valid  = |pend;
    if (age_hit && pend[3]) begin
      winner = SRC_WB;
    end else if (pend[0]) begin
      winner = SRC_DDIRTY;
    end else if (pend[1]) begin
      winner = SRC_DREFILL;
    end else if (pend[2]) begin
      winner = SRC_IREFILL;
    end else if (pend[3]) begin
      winner = SRC_WB;
    end
  end

endmodule

// File: rtl/l2_port_arbiter.sv
// Purpose: shares the L1->L2 request port among DL1 dirty, DL1 refill, IL1 refill, WB drain.
// Latency: trigger at edge N -> l2_req after edge N+1; l2_done at edge M -> req_done after edge M.
// Backpressure: l2_req and payload hold until l2_ack; triggers stay pending until served.
module l2_port_arbiter
  import l2_port_arbiter_pkg::*;
#(
  parameter int ADDR_W    = L2ARB_ADDR_W_DEF,
  parameter int AGE_LIMIT = L2ARB_AGE_LIMIT_DEF
) (
  input  logic                                   cache_clk,
  input  logic                                   rst_n,
  input  logic [L2ARB_NUM_SRC-1:0]               req_trig,
  input  logic [L2ARB_NUM_SRC-1:0][ADDR_W-1:0]   req_addr,
  output logic                                   l2_req,
  output logic [1:0]                             l2_src,
  output logic                                   l2_write,
  output logic [ADDR_W-1:0]                      l2_addr,
  input  logic                                   l2_ack,
  input  logic                                   l2_done,
  output logic [L2ARB_NUM_SRC-1:0]               req_done,
  output logic                                   arb_busy,
  output logic                                   trig_overrun
);

  localparam int AGE_W = $clog2(AGE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(AGE_LIMIT);

  arb_state_e                             state, state_n;
  logic [L2ARB_NUM_SRC-1:0]               pend, pend_n, served, accept, drop;
  logic [L2ARB_NUM_SRC-1:0][ADDR_W-1:0]   addr_q;
  logic [AGE_W-1:0]                       age_cnt, age_n;
  arb_src_e                               src_q, src_n, winner;
  logic                                   pick_vld, finish;
  logic                                   req_n, write_n, busy_n;
  logic [ADDR_W-1:0]                      addr_n;
  logic [L2ARB_NUM_SRC-1:0]               done_n;

  l2_arb_pick u_pick (
    .pend    (pend),
    .age_hit (age_cnt == AGE_MAX),
    .winner  (winner),
    .valid   (pick_vld)
  );

  // A trigger landing on the same edge that retires its source is a fresh request.
  always_comb begin
    served = '0;
    finish = ((state == ARB_WAIT) && l2_done) ||
             ((state == ARB_ISSUE) && l2_ack && l2_done);
    if (finish) served[src_q] = 1'b1;
    accept = req_trig & (~pend | served);
    drop   = req_trig & pend & ~served;
    pend_n = (pend & ~served) | req_trig;
  end

  always_comb begin
    state_n = state;
    req_n   = l2_req;
    src_n   = src_q;
    write_n = l2_write;
    addr_n  = l2_addr;
    busy_n  = arb_busy;
    done_n  = '0;
    age_n   = age_cnt;
    unique case (state)
      ARB_IDLE: begin
        if (pick_vld) begin
          req_n   = 1'b1;
          src_n   = winner;
          write_n = src_is_write(winner);
          addr_n  = addr_q[winner];
          state_n = ARB_ISSUE;
          if (winner == SRC_WB) begin
            age_n = '0;
          end else if (pend[3] && (age_cnt != AGE_MAX)) begin
            age_n = age_cnt + AGE_W'(1);
          end
        end
      end
      ARB_ISSUE: begin
        if (l2_ack) begin
          req_n = 1'b0;
          if (l2_done) begin
            done_n[src_q] = 1'b1;
            state_n       = ARB_DONE;
          end else begin
            busy_n  = 1'b1;
            state_n = ARB_WAIT;
          end
        end
      end
      ARB_WAIT: begin
        if (l2_done) begin
          done_n[src_q] = 1'b1;
          busy_n        = 1'b0;
          state_n       = ARB_DONE;
        end
      end
      ARB_DONE: state_n = ARB_IDLE;
      default:  state_n = ARB_IDLE;
    endcase
  end

  always_ff @(posedge cache_clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ARB_IDLE;
      pend         <= '0;
      addr_q       <= '0;
      age_cnt      <= '0;
      src_q        <= SRC_DDIRTY;
      l2_req       <= 1'b0;
      l2_write     <= 1'b0;
      l2_addr      <= '0;
      req_done     <= '0;
      arb_busy     <= 1'b0;
      trig_overrun <= 1'b0;
    end else begin
      state        <= state_n;
      pend         <= pend_n;
      age_cnt      <= age_n;
      src_q        <= src_n;
      l2_req       <= req_n;
      l2_write     <= write_n;
      l2_addr      <= addr_n;
      req_done     <= done_n;
      arb_busy     <= busy_n;
      trig_overrun <= trig_overrun | (|drop);
      for (int i = 0; i < L2ARB_NUM_SRC; i++) begin
        if (accept[i]) addr_q[i] <= req_addr[i];
      end
    end
  end

  assign l2_src = src_q;

endmodule

// File: tb/tb_l2_port_arbiter.sv
// Directed bench for l2_port_arbiter: each task drives one scenario and checks inline.
module tb_l2_port_arbiter;

  logic             cache_clk = 1'b0;
  logic             rst_n     = 1'b1;
  logic [3:0]       req_trig  = '0;
  logic [3:0][31:0] req_addr  = '0;
  logic             l2_req;
  logic [1:0]       l2_src;
  logic             l2_write;
  logic [31:0]      l2_addr;
  logic             l2_ack    = 1'b0;
  logic             l2_done   = 1'b0;
  logic [3:0]       req_done;
  logic             arb_busy;
  logic             trig_overrun;

  int tests_run    = 0;
  int tests_failed = 0;

  l2_port_arbiter #(.ADDR_W(32), .AGE_LIMIT(4)) dut (
    .cache_clk    (cache_clk),
    .rst_n        (rst_n),
    .req_trig     (req_trig),
    .req_addr     (req_addr),
    .l2_req       (l2_req),
    .l2_src       (l2_src),
    .l2_write     (l2_write),
    .l2_addr      (l2_addr),
    .l2_ack       (l2_ack),
    .l2_done      (l2_done),
    .req_done     (req_done),
    .arb_busy     (arb_busy),
    .trig_overrun (trig_overrun)
  );

  always #5 cache_clk = ~cache_clk;

  task automatic tick();
    @(posedge cache_clk);
    #1;
  endtask

  // One-cycle trigger on the given sources, all loaded with the same address.
  task automatic pulse_trig(input logic [3:0] t, input logic [31:0] a);
    for (int i = 0; i < 4; i++) if (t[i]) req_addr[i] = a;
    req_trig = t;
    tick();
    req_trig = '0;
  endtask

  // From ARB_ISSUE: ack after ack_dly cycles, done after done_dly more; returns in ARB_DONE.
  task automatic serve(input int ack_dly, input int done_dly);
    repeat (ack_dly) tick();
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    repeat (done_dly) tick();
    l2_done = 1'b1;
    tick();
    l2_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    tests_run++; if (l2_req !== 1'b0) begin tests_failed++; $display("FAIL reset_l2_req got %b want 0", l2_req); end
    tests_run++; if (l2_addr !== 32'h0) begin tests_failed++; $display("FAIL reset_l2_addr got %h want 0", l2_addr); end
    tests_run++; if ({l2_src, l2_write, req_done, arb_busy, trig_overrun} !== 9'h0) begin
      tests_failed++; $display("FAIL reset_misc got %b want 0", {l2_src, l2_write, req_done, arb_busy, trig_overrun}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single_refill();
    int pulses;
    pulse_trig(4'b0010, 32'h0000_1040);
    tests_run++; if (l2_req !== 1'b0) begin tests_failed++; $display("FAIL t1_req_early got %b want 0", l2_req); end
    tick();
    tests_run++; if (l2_req !== 1'b1) begin tests_failed++; $display("FAIL t1_req got %b want 1", l2_req); end
    tests_run++; if (l2_src !== 2'd1) begin tests_failed++; $display("FAIL t1_src got %0d want 1", l2_src); end
    tests_run++; if (l2_write !== 1'b0) begin tests_failed++; $display("FAIL t1_write got %b want 0", l2_write); end
    tests_run++; if (l2_addr !== 32'h0000_1040) begin tests_failed++; $display("FAIL t1_addr got %h want 00001040", l2_addr); end
    tick();
    tests_run++; if (l2_req !== 1'b1) begin tests_failed++; $display("FAIL t1_req_hold got %b want 1", l2_req); end
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    tests_run++; if ({l2_req, arb_busy} !== 2'b01) begin tests_failed++; $display("FAIL t1_after_ack got %b want 01", {l2_req, arb_busy}); end
    pulses = 0;
    repeat (4) begin tick(); pulses += int'(req_done[1]); end
    l2_done = 1'b1;
    tick();
    l2_done = 1'b0;
    pulses += int'(req_done[1]);
    tests_run++; if (req_done !== 4'b0010) begin tests_failed++; $display("FAIL t1_req_done got %b want 0010", req_done); end
    tests_run++; if (arb_busy !== 1'b0) begin tests_failed++; $display("FAIL t1_busy_clr got %b want 0", arb_busy); end
    tick();
    pulses += int'(req_done[1]);
    tests_run++; if (req_done !== 4'b0000) begin tests_failed++; $display("FAIL t1_done_width got %b want 0000", req_done); end
    tests_run++; if (pulses !== 1) begin tests_failed++; $display("FAIL t1_pulse_count got %0d want 1", pulses); end
    tick();
  endtask

  task automatic test_priority();
    req_addr[0] = 32'hA000_0000;
    req_addr[1] = 32'h0000_2080;
    req_trig = 4'b0011;
    tick();
    req_trig = '0;
    tick();
    tests_run++; if ({l2_src, l2_write} !== 3'b001) begin tests_failed++; $display("FAIL t2_first got src/wr %b want 001", {l2_src, l2_write}); end
    tests_run++; if (l2_addr !== 32'hA000_0000) begin tests_failed++; $display("FAIL t2_first_addr got %h want a0000000", l2_addr); end
    serve(0, 1);
    tests_run++; if (req_done !== 4'b0001) begin tests_failed++; $display("FAIL t2_done0 got %b want 0001", req_done); end
    tick();
    tests_run++; if (l2_req !== 1'b0) begin tests_failed++; $display("FAIL t2_bubble got %b want 0", l2_req); end
    tick();
    tests_run++; if ({l2_req, l2_src, l2_write} !== 4'b1010) begin tests_failed++; $display("FAIL t2_second got %b want 1010", {l2_req, l2_src, l2_write}); end
    tests_run++; if (l2_addr !== 32'h0000_2080) begin tests_failed++; $display("FAIL t2_second_addr got %h want 00002080", l2_addr); end
    serve(0, 0);
    tick();
  endtask

  task automatic test_wb_aging();
    req_addr[2] = 32'h0000_3000;
    req_addr[3] = 32'h0000_4000;
    req_trig = 4'b1100;
    tick();
    req_trig = '0;
    tick();
    for (int k = 0; k < 4; k++) begin
      tests_run++; if (l2_src !== 2'd2) begin tests_failed++; $display("FAIL t3_il1_grant%0d got %0d want 2", k, l2_src); end
      serve(0, 0);
      req_trig = 4'b0100;
      tick();
      req_trig = '0;
      tick();
    end
    tests_run++; if ({l2_req, l2_src, l2_write} !== 4'b1111) begin tests_failed++; $display("FAIL t3_wb_grant got %b want 1111", {l2_req, l2_src, l2_write}); end
    tests_run++; if (l2_addr !== 32'h0000_4000) begin tests_failed++; $display("FAIL t3_wb_addr got %h want 00004000", l2_addr); end
    serve(0, 0);
    req_trig = 4'b1000;
    tick();
    req_trig = '0;
    tick();
    tests_run++; if (l2_src !== 2'd2) begin tests_failed++; $display("FAIL t3_age_cleared got %0d want 2", l2_src); end
    serve(0, 0);
    tick();
    tick();
    tests_run++; if (l2_src !== 2'd3) begin tests_failed++; $display("FAIL t3_wb_last got %0d want 3", l2_src); end
    serve(0, 0);
    tick();
  endtask

  task automatic test_overrun();
    tests_run++; if (trig_overrun !== 1'b0) begin tests_failed++; $display("FAIL t4_pre got %b want 0", trig_overrun); end
    pulse_trig(4'b0100, 32'h0000_5000);
    tick();
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    pulse_trig(4'b0100, 32'h0000_6000);
    tests_run++; if (trig_overrun !== 1'b1) begin tests_failed++; $display("FAIL t4_overrun got %b want 1", trig_overrun); end
    tests_run++; if (l2_addr !== 32'h0000_5000) begin tests_failed++; $display("FAIL t4_addr_hold got %h want 00005000", l2_addr); end
    l2_done = 1'b1;
    tick();
    l2_done = 1'b0;
    tests_run++; if (req_done !== 4'b0100) begin tests_failed++; $display("FAIL t4_done got %b want 0100", req_done); end
    tick();
    tick();
    tick();
    tests_run++; if (l2_req !== 1'b0) begin tests_failed++; $display("FAIL t4_no_reissue got %b want 0", l2_req); end
    tests_run++; if (trig_overrun !== 1'b1) begin tests_failed++; $display("FAIL t4_sticky got %b want 1", trig_overrun); end
  endtask

  task automatic test_ack_done_same();
    pulse_trig(4'b0001, 32'h0000_7000);
    tick();
    l2_ack  = 1'b1;
    l2_done = 1'b1;
    tick();
    l2_ack  = 1'b0;
    l2_done = 1'b0;
    tests_run++; if ({req_done, l2_req, arb_busy} !== 6'b000100) begin tests_failed++; $display("FAIL t5_done got %b want 000100", {req_done, l2_req, arb_busy}); end
    req_addr[2] = 32'h0000_7100;
    req_trig = 4'b0100;
    tick();
    req_trig = '0;
    tests_run++; if ({req_done, l2_req} !== 5'b00000) begin tests_failed++; $display("FAIL t5_bubble got %b want 00000", {req_done, l2_req}); end
    tick();
    tests_run++; if ({l2_req, l2_src} !== 3'b110) begin tests_failed++; $display("FAIL t5_next_grant got %b want 110", {l2_req, l2_src}); end
    tests_run++; if (l2_addr !== 32'h0000_7100) begin tests_failed++; $display("FAIL t5_next_addr got %h want 00007100", l2_addr); end
    serve(0, 0);
    tick();
  endtask

  task automatic test_reset_mid_op();
    pulse_trig(4'b0010, 32'h0000_8000);
    tick();
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    tests_run++; if (arb_busy !== 1'b1) begin tests_failed++; $display("FAIL t6_busy got %b want 1", arb_busy); end
    #2 rst_n = 1'b0;
    #1;
    tests_run++; if ({l2_req, l2_src, l2_write, req_done, arb_busy, trig_overrun} !== 10'h0) begin
      tests_failed++; $display("FAIL t6_async_clear got %b want 0", {l2_req, l2_src, l2_write, req_done, arb_busy, trig_overrun}); end
    tests_run++; if (l2_addr !== 32'h0) begin tests_failed++; $display("FAIL t6_addr_clear got %h want 0", l2_addr); end
    l2_done = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    tests_run++; if (req_done !== 4'b0000) begin tests_failed++; $display("FAIL t6_stray_done got %b want 0000", req_done); end
    l2_done = 1'b0;
    pulse_trig(4'b0010, 32'h0000_9000);
    tick();
    tests_run++; if ({l2_req, l2_src, l2_addr} !== {1'b1, 2'd1, 32'h0000_9000}) begin
      tests_failed++; $display("FAIL t6_after_reset got %b/%0d/%h want 1/1/00009000", l2_req, l2_src, l2_addr); end
    serve(0, 1);
    tests_run++; if (req_done !== 4'b0010) begin tests_failed++; $display("FAIL t6_served got %b want 0010", req_done); end
    tick();
  endtask

  task automatic test_trig_at_done();
    pulse_trig(4'b0100, 32'h0000_A100);
    tick();
    l2_ack = 1'b1;
    tick();
    l2_ack = 1'b0;
    l2_done = 1'b1;
    req_addr[2] = 32'h0000_A200;
    req_trig = 4'b0100;
    tick();
    l2_done = 1'b0;
    req_trig = '0;
    tests_run++; if ({req_done, trig_overrun} !== 5'b01000) begin tests_failed++; $display("FAIL t7_done_no_ovr got %b want 01000", {req_done, trig_overrun}); end
    tick();
    tick();
    tests_run++; if ({l2_req, l2_src, l2_addr} !== {1'b1, 2'd2, 32'h0000_A200}) begin
      tests_failed++; $display("FAIL t7_regrant got %b/%0d/%h want 1/2/0000a200", l2_req, l2_src, l2_addr); end
    serve(0, 0);
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_single_refill();
    test_priority();
    test_wb_aging();
    test_overrun();
    test_ack_done_same();
    test_reset_mid_op();
    test_trig_at_done();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
